// File: rtl/lane_arbiter_rr.sv
// Four-lane FIFO-buffered round-robin arbiter with a registered output stage.
// Define LANE0_PRIORITY_EN to give lane 0 strict priority over lanes 1..3.
//
// state | meaning
// EMPTY | output register holds no word (validOut=0)
// HOLD  | output register holds a word awaiting readyOut (validOut=1)
module lane_arbiter_rr #(
  parameter int DEPTH = 2
) (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [7:0] dataIn0,
  input  logic [7:0] dataIn1,
  input  logic [7:0] dataIn2,
  input  logic [7:0] dataIn3,
  input  logic       validIn0,
  input  logic       validIn1,
  input  logic       validIn2,
  input  logic       validIn3,
  output logic       readyIn0,
  output logic       readyIn1,
  output logic       readyIn2,
  output logic       readyIn3,
  output logic [7:0] dataOut,
  output logic       validOut,
  input  logic       readyOut,
  output logic [1:0] grant
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {EMPTY, HOLD} stateT;

  stateT state, stateNext;

  logic [7:0]    mem [4][DEPTH];
  logic [PW-1:0] rdPtr [4];
  logic [PW-1:0] wrPtr [4];
  logic [CW-1:0] count [4];
  logic [7:0]    dataVec [4];

  logic [3:0] validVec, readyVec, nonEmpty, pushVec, popVec;
  logic [1:0] lastGrant, pick, rrIdx;
  logic       found, load;

  assign dataVec[0] = dataIn0;
  assign dataVec[1] = dataIn1;
  assign dataVec[2] = dataIn2;
  assign dataVec[3] = dataIn3;
  assign validVec   = {validIn3, validIn2, validIn1, validIn0};

  assign readyIn0 = readyVec[0];
  assign readyIn1 = readyVec[1];
  assign readyIn2 = readyVec[2];
  assign readyIn3 = readyVec[3];

  assign validOut = (state == HOLD);

  // Acceptance looks only at the current count, so a full lane stays closed even while popped.
  always_comb begin
    nonEmpty = '0;
    readyVec = '0;
    pushVec  = '0;
    for (int i = 0; i < 4; i++) begin
      nonEmpty[i] = (count[i] != '0);
      readyVec[i] = !reset && (count[i] < FULL);
      pushVec[i]  = validVec[i] && readyVec[i];
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    rrIdx = '0;
    for (int k = 1; k <= 4; k++) begin
      rrIdx = lastGrant + 2'(k);
      if (!found && nonEmpty[rrIdx]) begin
        pick  = rrIdx;
        found = 1'b1;
      end
    end
`ifdef LANE0_PRIORITY_EN
    if (nonEmpty[0]) pick = 2'd0;
`endif
  end

  always_comb begin
    stateNext = state;
    load      = ((state == EMPTY) || readyOut) && (|nonEmpty);
    popVec    = load ? (4'b0001 << pick) : 4'b0000;
    if (load) stateNext = HOLD;
    else if (state == HOLD && readyOut) stateNext = EMPTY;
  end

  always_ff @(posedge clk_1) begin
    if (reset) begin
      state     <= EMPTY;
      dataOut   <= '0;
      grant     <= '0;
      lastGrant <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        rdPtr[i] <= '0;
        wrPtr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      state <= stateNext;
      if (load) begin
        dataOut <= mem[pick][rdPtr[pick]];
        grant   <= pick;
`ifdef LANE0_PRIORITY_EN
        if (pick != 2'd0) lastGrant <= pick;
`else
        lastGrant <= pick;
`endif
      end
      for (int i = 0; i < 4; i++) begin
        if (pushVec[i]) wrPtr[i] <= wrPtr[i] + 1'b1;
        if (popVec[i])  rdPtr[i] <= rdPtr[i] + 1'b1;
        case ({pushVec[i], popVec[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage carries no reset; pushes are already blocked while reset is high.
  always_ff @(posedge clk_1) begin
    for (int i = 0; i < 4; i++) begin
      if (pushVec[i]) mem[i][wrPtr[i]] <= dataVec[i];
    end
  end

endmodule

// File: doc/lane_arbiter_rr.md
LANE_ARBITER_RR -- requirements
Module: lane_arbiter_rr

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-lane FIFO depth in words (power of 2, 2..8).
REQ-002 SHALL have port clk_1  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports dataIn0..dataIn3  input  8  per-lane request data.
REQ-005 SHALL have ports validIn0..validIn3  input  1  per-lane data valid.
REQ-006 SHALL have ports readyIn0..readyIn3  output  1  per-lane FIFO can accept a word.
REQ-007 SHALL have port dataOut  output  8  granted word.
REQ-008 SHALL have port validOut  output  1  dataOut holds a word.
REQ-009 SHALL have port readyOut  input  1  downstream accepts dataOut.
REQ-010 SHALL have port grant  output  2  source lane index of the word in dataOut.

Function
REQ-011 SHALL push dataInN into lane N FIFO on a rising edge where validInN=1 and readyInN=1.
REQ-012 SHALL drive readyInN = !reset && (countN < DEPTH), independent of same-cycle pops; a full lane SHALL NOT accept a push even while it is popped.
REQ-013 SHALL preserve word order within each lane; no word dropped or duplicated.
REQ-014 SHALL implement a 2-state output FSM: EMPTY (validOut=0), HOLD (validOut=1).
REQ-015 SHALL assert load when (EMPTY or (HOLD and readyOut=1)) and at least one FIFO is non-empty.
REQ-016 On load SHALL pop the chosen lane, register its head word into dataOut, set grant to its index, enter/stay in HOLD.
REQ-017 In HOLD with readyOut=1 and no non-empty FIFO, SHALL enter EMPTY; dataOut and grant retain last values.
REQ-018 In HOLD with readyOut=0, SHALL hold dataOut, grant, validOut stable.
REQ-019 SHALL choose the lane by round-robin: first non-empty lane scanning last_grant+1, +2, +3, +4 (mod 4).
REQ-020 SHALL update last_grant to the chosen lane on every load only.
REQ-021 SHALL not bypass FIFOs: word pushed at edge k into an empty lane is at dataOut after edge k+1 at earliest (2-edge latency).
REQ-022 Same-cycle push and pop on one lane SHALL leave countN unchanged and succeed when countN was 1..DEPTH-1.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; countN SHALL range 0..DEPTH.
REQ-024 With all four lanes continuously backlogged and readyOut=1, grant SHALL sequence 0,1,2,3,0,... one word per cycle.

Reset
REQ-025 While reset=1 at a rising edge, SHALL clear all FIFO counts and pointers, set FSM to EMPTY, validOut=0, dataOut=8'h00, grant=0, last_grant=3.
REQ-026 SHALL ignore validInN and readyOut while reset=1; readyInN SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all buffered and held words; first grant after reset SHALL go to the lowest non-empty lane from lane 0.

Configuration
REQ-028 With macro LANE0_PRIORITY_EN defined, a non-empty lane 0 SHALL win every load; lanes 1..3 round-robin among themselves only when lane 0 is empty; last_grant SHALL update only on lane 1..3 grants.
REQ-029 Without LANE0_PRIORITY_EN, SHALL use pure 4-lane round-robin per REQ-019.

Verification
REQ-030 Reset then all lanes push one word (0xFF,0x15,0x37,0x51) same edge, readyOut=1 -> dataOut 0xFF,0x15,0x37,0x51 on consecutive cycles, grant 0,1,2,3, then validOut=0.
REQ-031 Lane 2 pushes 3 words (0x01,0x02,0x03) with readyOut=0, DEPTH=2 -> readyIn2 low after 2 buffered + 1 held; release readyOut -> 0x01,0x02,0x03 in order.
REQ-032 validOut=1, readyOut=0 for 5 cycles -> dataOut and grant unchanged; other lanes fill to DEPTH and stall.
REQ-033 Reset asserted with words in lanes 0 and 3 -> next cycle validOut=0, readyIn all 0 then 1 after release, no stale word emitted.
REQ-034 Lanes 0 and 1 backlogged, LANE0_PRIORITY_EN defined -> grant stays 0 until lane 0 empty; undefined -> grant alternates 0,1,0,1.
